vscpu_boot_loader: RTL and testbench
====================================

Name: vscpu_boot_loader

Overview:
- Upstream stage of the VSCPU top: receives a framed byte stream (from a UART receiver or a bench driver), assembles 32-bit instruction/data words and writes them into the unified 16384x32 RAM through a write port.
- Holds the CPU in reset while loading and releases it only after a frame with a valid checksum.
- Replaces hierarchical memory preloading, so boot images can be loaded in-system.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- ADDR_W, 14, RAM word-address width (matches the instruction A/B fields).
- DATA_W, 32, RAM word width.
- MEM_DEPTH, 16384, number of RAM words; the largest legal word count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte this cycle; the byte transfers when in_valid && in_ready.
- start  in  1  single-cycle pulse that re-arms the loader from DONE or ERR.
- mem_we  out  1  RAM write strobe, one cycle per word.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  DATA_W  RAM write data.
- cpu_rst  out  1  active-high reset to the CPU; high while loading.
- done  out  1  image loaded, checksum good.
- err  out  1  frame rejected.

Behaviour:
- Reset values:
  - state IDLE, in_ready=1, cpu_rst=1.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - done=0, err=0, checksum accumulator=0.
- Frame format, all fields big-endian: SYNC_BYTE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words of 4 bytes each (MSB first), then CHK.
  - Start address = {ADDR_HI, ADDR_LO}[ADDR_W-1:0]; upper bits are ignored.
- States:
  - IDLE: accepted bytes other than SYNC_BYTE are discarded silently. SYNC_BYTE clears the accumulator and goes to A_HI.
  - A_HI -> A_LO -> C_HI -> C_LO: one accepted byte each.
  - After C_LO:
    - CNT > MEM_DEPTH goes to ERR.
    - CNT == 0 goes to CHK.
    - Otherwise goes to DATA with byte index 0.
  - DATA: shifts bytes into a word register.
    - On the 4th byte, a registered write fires: mem_we=1 for exactly one cycle in the following cycle, with mem_addr = current pointer and mem_wdata = the assembled word.
    - The pointer then increments modulo MEM_DEPTH, so 16383 wraps to 0.
    - The remaining count decrements; at 0 the state goes to CHK.
  - CHK: one accepted byte. The 8-bit sum of every byte after SYNC (address, count, data, CHK) must equal 8'h00.
    - Sum is 0: go to DONE.
    - Otherwise: go to ERR.
  - DONE: done=1, cpu_rst=0, in_ready=0.
  - ERR: err=1, cpu_rst=1, in_ready=0.
  - start in DONE or ERR returns to IDLE: cpu_rst=1, done=0, err=0, in_ready=1. start is ignored in all other states.
- Throughput: in_ready stays 1 in states IDLE through CHK, so one byte per cycle is sustained. The write of word k overlaps the reception of word k+1, and the design has no back-pressure.
- in_valid low stalls the FSM indefinitely; there is no timeout.
- Words already written before an ERR remain in RAM and are not rolled back.
- Reset mid-frame aborts immediately: outputs return to their reset values and no partial word is written.
- cpu_rst changes only in registered form and is glitch-free.

Decomposition:
- Shared package vscpu_pkg holds:
  - ADDR_W and DATA_W.
  - The opcode constants (ADD=0 .. MULi=F).
  - The loader state enum and SYNC_BYTE.
- Optional sub-module vscpu_word_assembler: byte shift register plus 2-bit index, emitting word_valid. The FSM, counter and checksum stay in the top loader.

Test Plan:
- Single word: stream A5 00 00 00 01 90 1B 80 03 D1 -> one mem_we with addr 0 and data 32'h901B8003 (CPi 110,3); then done=1, cpu_rst=0, err=0.
- Bad checksum: same frame with CHK=D2 -> the addr-0 write still occurs; then err=1, done=0, cpu_rst stays 1; start returns the loader to IDLE with in_ready=1.
- Wrap-around: A5 3F FF 00 02, words 11111111 and 22222222, correct CHK -> writes at addr 16383 then addr 0; done=1.
- Illegal count: A5 00 00 40 01 -> err=1 right after the CNT_LO byte; no mem_we is asserted.
- Garbage and stalls: bytes 00 FF 5A before SYNC, plus random in_valid gaps inside a 3-word frame at addr 100 (values 5, 8, 16) -> the garbage is ignored; exactly 3 writes to addrs 100-102 in order; done=1.
- Reset mid-frame: rst low during the 2nd byte of a data word -> no mem_we; state IDLE and cpu_rst=1 immediately. A subsequent full frame loads correctly.

Source files
------------

// File: rtl/vscpu_pkg.sv
// Shared VSCPU constants: RAM geometry, opcode encoding and boot loader states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vscpu_pkg;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 16384;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_ADDI  = 4'h1,
        OP_NAND  = 4'h2,
        OP_NANDI = 4'h3,
        OP_SRL   = 4'h4,
        OP_SRLI  = 4'h5,
        OP_LT    = 4'h6,
        OP_LTI   = 4'h7,
        OP_CP    = 4'h8,
        OP_CPI   = 4'h9,
        OP_CPIN  = 4'hA,
        OP_CPINI = 4'hB,
        OP_BZJ   = 4'hC,
        OP_BZJI  = 4'hD,
        OP_MUL   = 4'hE,
        OP_MULI  = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A_HI,
        ST_A_LO,
        ST_C_HI,
        ST_C_LO,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } ldr_state_t;

endpackage

// File: rtl/vscpu_word_assembler.sv
// Packs four big-endian bytes into one RAM word.
// Latency: word_vld/word_dat are combinational with the 4th accepted byte.
// Backpressure: none; consumes every byte_vld cycle.
module vscpu_word_assembler
    import vscpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_vld,
    input  logic [7:0]        byte_dat,
    output logic              word_vld,
    output logic [DATA_W-1:0] word_dat
);

    logic [23:0] shreg;
    logic [1:0]  idx;

    assign word_vld = byte_vld && (idx == 2'd3);
    assign word_dat = {shreg, byte_dat};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            idx   <= '0;
        end else if (byte_vld) begin
            shreg <= {shreg[15:0], byte_dat};
            idx   <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/vscpu_boot_loader.sv
// Frame-driven RAM loader; holds the CPU in reset until a checksum-clean image lands.
// Latency: RAM write one cycle after each word's 4th byte; done/err one cycle after CHK.
// Backpressure: in_ready high from IDLE through CHK (1 byte/cycle), low in DONE/ERR until start.
module vscpu_boot_loader
    import vscpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam logic [15:0] MAX_CNT = 16'(MEM_DEPTH);

    ldr_state_t        state;
    logic [7:0]        hdr_hi;
    logic [7:0]        acc;
    logic [15:0]       rem;
    logic [ADDR_W-1:0] ptr;
    logic              xfer;
    logic              word_vld;
    logic [DATA_W-1:0] word_dat;
    logic [15:0]       hdr_word;
    logic [7:0]        sum_nxt;

    assign xfer     = in_valid && in_ready;
    assign hdr_word = {hdr_hi, in_data};
    assign sum_nxt  = acc + in_data;

    vscpu_word_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .byte_vld (xfer && (state == ST_DATA)),
        .byte_dat (in_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            cpu_rst   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            acc       <= '0;
            hdr_hi    <= '0;
            rem       <= '0;
            ptr       <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE: if (xfer && in_data == SYNC_BYTE) begin
                    acc   <= '0;
                    state <= ST_A_HI;
                end
                ST_A_HI: if (xfer) begin
                    acc    <= sum_nxt;
                    hdr_hi <= in_data;
                    state  <= ST_A_LO;
                end
                ST_A_LO: if (xfer) begin
                    acc   <= sum_nxt;
                    ptr   <= hdr_word[ADDR_W-1:0];
                    state <= ST_C_HI;
                end
                ST_C_HI: if (xfer) begin
                    acc    <= sum_nxt;
                    hdr_hi <= in_data;
                    state  <= ST_C_LO;
                end
                ST_C_LO: if (xfer) begin
                    acc <= sum_nxt;
                    rem <= hdr_word;
                    if (hdr_word > MAX_CNT) begin
                        state    <= ST_ERR;
                        err      <= 1'b1;
                        in_ready <= 1'b0;
                    end else if (hdr_word == 16'd0) begin
                        state <= ST_CHK;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                // Write of word k is issued here while word k+1 streams in.
                ST_DATA: if (xfer) begin
                    acc <= sum_nxt;
                    if (word_vld) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= word_dat;
                        ptr       <= ptr + ADDR_W'(1);
                        rem       <= rem - 16'd1;
                        if (rem == 16'd1)
                            state <= ST_CHK;
                    end
                end
                ST_CHK: if (xfer) begin
                    acc      <= sum_nxt;
                    in_ready <= 1'b0;
                    if (sum_nxt == 8'h00) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        state <= ST_ERR;
                        err   <= 1'b1;
                    end
                end
                ST_DONE, ST_ERR: if (start) begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                    cpu_rst  <= 1'b1;
                    done     <= 1'b0;
                    err      <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vscpu_boot_loader.sv
// Randomized bench for vscpu_boot_loader against a frame-level parsing model.
module tb_vscpu_boot_loader;
    import vscpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  stim[$];
    logic [31:0] wq[$];
    logic [45:0] exp_wr[$];
    logic [45:0] got_wr[$];
    int          exp_status;

    vscpu_boot_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (mem_we === 1'b1)
            got_wr.push_back({mem_addr, mem_wdata});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Parses the whole byte stream as a frame: expected writes plus 0=open, 1=done, 2=err.
    function automatic void model();
        int         i;
        int         addr;
        int         cnt;
        logic [7:0] sum;
        exp_wr.delete();
        exp_status = 0;
        i = 0;
        while (i < stim.size() && stim[i] != SYNC_BYTE) i++;
        if (i + 5 > stim.size()) return;
        addr = (int'(stim[i+1]) * 256 + int'(stim[i+2])) % MEM_DEPTH;
        cnt  = int'(stim[i+3]) * 256 + int'(stim[i+4]);
        sum  = stim[i+1] + stim[i+2] + stim[i+3] + stim[i+4];
        i += 5;
        if (cnt > MEM_DEPTH) begin
            exp_status = 2;
            return;
        end
        for (int k = 0; k < cnt; k++) begin
            if (i + 4 > stim.size()) return;
            exp_wr.push_back({14'((addr + k) % MEM_DEPTH), stim[i], stim[i+1], stim[i+2], stim[i+3]});
            sum = sum + stim[i] + stim[i+1] + stim[i+2] + stim[i+3];
            i += 4;
        end
        if (i >= stim.size()) return;
        sum = sum + stim[i];
        exp_status = (sum == 8'h00) ? 1 : 2;
    endfunction

    task automatic add_frame(input logic [15:0] addr, input logic [15:0] cnt, input logic bad);
        logic [7:0]  sum;
        logic [7:0]  ck;
        logic [31:0] w;
        stim.push_back(SYNC_BYTE);
        stim.push_back(addr[15:8]);
        stim.push_back(addr[7:0]);
        stim.push_back(cnt[15:8]);
        stim.push_back(cnt[7:0]);
        sum = addr[15:8] + addr[7:0] + cnt[15:8] + cnt[7:0];
        for (int k = 0; k < int'(cnt) && k < wq.size(); k++) begin
            w = wq[k];
            for (int j = 3; j >= 0; j--) begin
                stim.push_back(w[j*8 +: 8]);
                sum = sum + w[j*8 +: 8];
            end
        end
        ck = 8'h00 - sum;
        if (bad) ck = ck ^ 8'($urandom_range(1, 255));
        stim.push_back(ck);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        check("in_ready", in_ready, 1'b1);
    endtask

    task automatic run_frame(input string tag, input int max_gap);
        got_wr.delete();
        model();
        for (int i = 0; i < stim.size(); i++)
            send_byte(stim[i], $urandom_range(0, max_gap));
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".done"}, done, exp_status == 1);
        check({tag, ".err"}, err, exp_status == 2);
        check({tag, ".cpu_rst"}, cpu_rst, exp_status != 1);
        check({tag, ".in_ready"}, in_ready, exp_status == 0);
        repeat (3) @(negedge clk);
        check({tag, ".nwr"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check({tag, ".wr"}, got_wr[i], exp_wr[i]);
        if (exp_status != 0) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, ".rearm_rdy"}, in_ready, 1'b1);
            check({tag, ".rearm_done"}, done, 1'b0);
            check({tag, ".rearm_err"}, err, 1'b0);
            check({tag, ".rearm_cpu"}, cpu_rst, 1'b1);
        end
        stim.delete();
        wq.delete();
    endtask

    initial begin
        logic [7:0] g;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.in_ready", in_ready, 1'b1);
        check("rst.cpu_rst", cpu_rst, 1'b1);
        check("rst.mem_we", mem_we, 1'b0);
        check("rst.mem_addr", mem_addr, '0);
        check("rst.mem_wdata", mem_wdata, '0);
        check("rst.done", done, 1'b0);
        check("rst.err", err, 1'b0);
        rst = 1'b1;

        stim = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h90, 8'h1B, 8'h80, 8'h03, 8'hD1};
        run_frame("single", 0);
        check("single.word", (got_wr.size() > 0) ? got_wr[0] : '0, {14'd0, 32'h901B8003});

        stim = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h90, 8'h1B, 8'h80, 8'h03, 8'hD2};
        run_frame("badchk", 0);

        wq = {32'h11111111, 32'h22222222};
        add_frame(16'h3FFF, 16'd2, 1'b0);
        run_frame("wrap", 0);

        stim = {8'hA5, 8'h00, 8'h00, 8'h40, 8'h01};
        run_frame("illegal", 0);

        stim = {8'h00, 8'hFF, 8'h5A};
        wq   = {32'd5, 32'd8, 32'd16};
        add_frame(16'd100, 16'd3, 1'b0);
        run_frame("stall", 3);

        got_wr.delete();
        stim = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12};
        for (int i = 0; i < stim.size(); i++)
            send_byte(stim[i], 0);
        stim.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h34;
        #2 rst = 1'b0;
        #1;
        check("midrst.in_ready", in_ready, 1'b1);
        check("midrst.cpu_rst", cpu_rst, 1'b1);
        check("midrst.done", done, 1'b0);
        check("midrst.mem_we", mem_we, 1'b0);
        check("midrst.mem_wdata", mem_wdata, '0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst.nwr", got_wr.size(), 0);
        wq = {32'hCAFEF00D, 32'h0BADBEEF};
        add_frame(16'h0010, 16'd2, 1'b0);
        run_frame("postrst", 1);

        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(0, 3)) begin
                g = 8'($urandom);
                if (g == SYNC_BYTE) g = 8'h00;
                stim.push_back(g);
            end
            for (int k = 0; k < 5; k++) wq.push_back($urandom);
            add_frame(16'($urandom), 16'($urandom_range(0, 5)), ($urandom_range(0, 2) == 0));
            run_frame("rand", 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
